stack_flow_ctrl: RTL and testbench

- Multi-cycle sequencer for CALL, RET, INT and RTI in the five-stage pipeline.
- PC and SP are 32 bits but the data memory port is 16 bits, so control transfers move 2–3 words through the memory stage.
- Raises stall to freeze fetch/decode while it owns the data-memory port. Updates SP once, PC once and CCR once, on its final cycle.
- Sits between the control unit / DE register and the DataMem port, next to the register file's SP/PC/CCR write ports.

---
 rtl/stack_flow_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_stack_flow_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_flow_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : stack_flow_ctrl
// Brief    : CALL/RET/INT/RTI sequencer moving a 32-bit PC through a 16-bit
//            data-memory port. Optional macro STACK_FLOW_CCR_SAVE_EN adds CCR
//            push on INT and CCR pop on RTI.
// Revision : 1.0
// =============================================================================
module stack_flow_ctrl #(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              rti_req,
    input  logic              int_req,
    input  logic [31:0]       pc_in,
    input  logic [15:0]       call_target,
    input  logic [31:0]       sp_in,
    input  logic [4:0]        ccr_in,
    input  logic [15:0]       mem_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              stall,
    output logic              pc_wr,
    output logic [31:0]       pc_out,
    output logic              sp_wr,
    output logic [31:0]       sp_out,
    output logic              ccr_wr,
    output logic [4:0]        ccr_out,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, CAPT, FINISH
    } state_t;

    state_t      state;
    logic        pending;
    logic        is_int;
    logic [31:0] sp_lat;
    logic [15:0] pc_lo_lat;
    logic [15:0] tgt_lat;
    logic [15:0] lo_cap;

    logic int_any;
    logic any_req;
    assign int_any = int_req | pending;
    assign any_req = int_any | rti_req | ret_req | call_req;

    assign busy  = (state != IDLE);
    assign stall = busy | ((state == IDLE) & any_req);

    // Address offsets are taken on the low bits only; modular arithmetic keeps them exact.
    logic [ADDR_W-1:0] a_in, a_in_p1, a_lat_m1, a_lat_p2;
    assign a_in     = sp_in[ADDR_W-1:0];
    assign a_in_p1  = a_in + ADDR_W'(1);
    assign a_lat_m1 = sp_lat[ADDR_W-1:0] - ADDR_W'(1);
    assign a_lat_p2 = sp_lat[ADDR_W-1:0] + ADDR_W'(2);

    logic [31:0] push_pc;
    assign push_pc = is_int ? INT_VECTOR : {16'h0000, tgt_lat};

`ifdef STACK_FLOW_CCR_SAVE_EN
    logic              is_rti;
    logic [4:0]        ccr_lat;
    logic [4:0]        ccr_cap;
    logic [ADDR_W-1:0] a_lat_m2, a_lat_p3;
    assign a_lat_m2 = sp_lat[ADDR_W-1:0] - ADDR_W'(2);
    assign a_lat_p3 = sp_lat[ADDR_W-1:0] + ADDR_W'(3);
`else
    logic unused_ccr;
    assign unused_ccr = ^ccr_in;
    assign ccr_wr     = 1'b0;
    assign ccr_out    = 5'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            is_int    <= 1'b0;
            sp_lat    <= '0;
            pc_lo_lat <= '0;
            tgt_lat   <= '0;
            lo_cap    <= '0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc_wr     <= 1'b0;
            pc_out    <= '0;
            sp_wr     <= 1'b0;
            sp_out    <= '0;
`ifdef STACK_FLOW_CCR_SAVE_EN
            is_rti    <= 1'b0;
            ccr_lat   <= '0;
            ccr_cap   <= '0;
            ccr_wr    <= 1'b0;
            ccr_out   <= '0;
`endif
        end else begin
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc_wr     <= 1'b0;
            pc_out    <= '0;
            sp_wr     <= 1'b0;
            sp_out    <= '0;
`ifdef STACK_FLOW_CCR_SAVE_EN
            ccr_wr    <= 1'b0;
            ccr_out   <= '0;
`endif
            if (int_req) pending <= 1'b1;

            case (state)
                IDLE: if (any_req) begin
                    sp_lat    <= sp_in;
                    pc_lo_lat <= pc_in[15:0];
                    tgt_lat   <= call_target;
                    pending   <= 1'b0;
                    is_int    <= int_any;
                    mem_en    <= 1'b1;
`ifdef STACK_FLOW_CCR_SAVE_EN
                    ccr_lat   <= ccr_in;
                    is_rti    <= rti_req & ~int_any;
`endif
                    if (int_any || !(rti_req || ret_req)) begin
                        state     <= PUSH_HI;
                        mem_rw    <= 1'b1;
                        mem_addr  <= a_in;
                        mem_wdata <= pc_in[31:16];
                    end else begin
                        mem_addr  <= a_in_p1;
`ifdef STACK_FLOW_CCR_SAVE_EN
                        state     <= rti_req ? POP_CCR : POP_LO;
`else
                        state     <= POP_LO;
`endif
                    end
                end
                PUSH_HI: begin
                    state     <= PUSH_LO;
                    mem_en    <= 1'b1;
                    mem_rw    <= 1'b1;
                    mem_addr  <= a_lat_m1;
                    mem_wdata <= pc_lo_lat;
                end
                PUSH_LO: begin
`ifdef STACK_FLOW_CCR_SAVE_EN
                    if (is_int) begin
                        state     <= PUSH_CCR;
                        mem_en    <= 1'b1;
                        mem_rw    <= 1'b1;
                        mem_addr  <= a_lat_m2;
                        mem_wdata <= {11'h000, ccr_lat};
                    end else begin
                        state  <= FINISH;
                        pc_wr  <= 1'b1;
                        pc_out <= push_pc;
                        sp_wr  <= 1'b1;
                        sp_out <= sp_lat - 32'd2;
                    end
`else
                    state  <= FINISH;
                    pc_wr  <= 1'b1;
                    pc_out <= push_pc;
                    sp_wr  <= 1'b1;
                    sp_out <= sp_lat - 32'd2;
`endif
                end
`ifdef STACK_FLOW_CCR_SAVE_EN
                PUSH_CCR: begin
                    state  <= FINISH;
                    pc_wr  <= 1'b1;
                    pc_out <= push_pc;
                    sp_wr  <= 1'b1;
                    sp_out <= sp_lat - 32'd3;
                end
                POP_CCR: begin
                    state    <= POP_LO;
                    mem_en   <= 1'b1;
                    mem_addr <= a_lat_p2;
                end
`endif
                POP_LO: begin
                    state    <= POP_HI;
                    mem_en   <= 1'b1;
`ifdef STACK_FLOW_CCR_SAVE_EN
                    // RTI: the CCR word read in POP_CCR arrives now.
                    if (is_rti) ccr_cap <= mem_rdata[4:0];
                    mem_addr <= is_rti ? a_lat_p3 : a_lat_p2;
`else
                    mem_addr <= a_lat_p2;
`endif
                end
                POP_HI: begin
                    state  <= CAPT;
                    lo_cap <= mem_rdata;
                end
                CAPT: begin
                    state  <= FINISH;
                    pc_wr  <= 1'b1;
                    pc_out <= {mem_rdata, lo_cap};
                    sp_wr  <= 1'b1;
`ifdef STACK_FLOW_CCR_SAVE_EN
                    sp_out  <= sp_lat + (is_rti ? 32'd3 : 32'd2);
                    ccr_wr  <= is_rti;
                    ccr_out <= is_rti ? ccr_cap : 5'd0;
`else
                    sp_out <= sp_lat + 32'd2;
`endif
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_flow_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_stack_flow_ctrl
// Brief    : Scoreboard bench: stack-level reference model vs stack_flow_ctrl.
// Revision : 1.0
// =============================================================================
module tb_stack_flow_ctrl;
    localparam int          ADDR_W     = 12;
    localparam logic [31:0] INT_VECTOR = 32'h0000_0010;
    localparam int K_CALL = 0, K_RET = 1, K_INT = 2, K_RTI = 3;
`ifdef STACK_FLOW_CCR_SAVE_EN
    localparam bit CCR_EN = 1'b1;
`else
    localparam bit CCR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, call_req, ret_req, rti_req, int_req;
    logic [31:0] pc_in, sp_in;
    logic [15:0] call_target, mem_rdata;
    logic [4:0]  ccr_in;
    logic mem_en, mem_rw, stall, pc_wr, sp_wr, ccr_wr, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [31:0] pc_out, sp_out;
    logic [4:0]  ccr_out;

    always #5 clk = ~clk;

    stack_flow_ctrl #(.ADDR_W(ADDR_W), .INT_VECTOR(INT_VECTOR)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
        .rti_req(rti_req), .int_req(int_req), .pc_in(pc_in),
        .call_target(call_target), .sp_in(sp_in), .ccr_in(ccr_in),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall),
        .pc_wr(pc_wr), .pc_out(pc_out), .sp_wr(sp_wr), .sp_out(sp_out),
        .ccr_wr(ccr_wr), .ccr_out(ccr_out), .busy(busy)
    );

    function automatic logic [15:0] fill(input int i);
        return 16'(i * 40503) ^ 16'hA5C3;
    endfunction

    function automatic logic [ADDR_W-1:0] ad(input logic [31:0] x);
        return x[ADDR_W-1:0];
    endfunction

    // Data memory seen by the DUT: read data valid the cycle after the read.
    logic [15:0] dmem [0:4095];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= fill(i);
        end else if (mem_en && mem_rw) begin
            dmem[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_rw) mem_rdata <= dmem[mem_addr];
    end

    // Reference model state and scoreboard queues
    typedef struct packed { logic rw; logic [ADDR_W-1:0] addr; logic [15:0] wdata; } mem_op_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] sp; logic ccr_wr; logic [4:0] ccr; } fin_t;
    logic [15:0] ref_mem [0:4095];
    logic [31:0] m_sp;
    mem_op_t     exp_mem[$];
    fin_t        exp_fin[$];
    int          exp_lat[$];
    int          checks = 0, errors = 0;
    int          drv_timeouts = 0;
    logic        mon_en = 1'b0, test_done = 1'b0;

    task automatic exp_write(input logic [31:0] a, input logic [15:0] d);
        mem_op_t op;
        op.rw = 1'b1; op.addr = ad(a); op.wdata = d;
        exp_mem.push_back(op);
        ref_mem[ad(a)] = d;
    endtask

    task automatic exp_read(input logic [31:0] a);
        mem_op_t op;
        op.rw = 1'b0; op.addr = ad(a); op.wdata = '0;
        exp_mem.push_back(op);
    endtask

    // Whole-operation model: stack words moved, final PC/SP/CCR and busy length.
    task automatic model_op(input int kind, input logic [31:0] pc,
                            input logic [15:0] tgt, input logic [4:0] ccr);
        logic [31:0] s;
        logic [15:0] w;
        fin_t f;
        int n;
        s = m_sp;
        f = '0;
        if (kind == K_CALL || kind == K_INT) begin
            exp_write(s, pc[31:16]);
            exp_write(s - 32'd1, pc[15:0]);
            n = 2;
            if (kind == K_INT && CCR_EN) begin
                exp_write(s - 32'd2, {11'h000, ccr});
                n = 3;
            end
            f.pc = (kind == K_INT) ? INT_VECTOR : {16'h0000, tgt};
            f.sp = s - 32'(n);
            exp_lat.push_back(n + 1);
        end else begin
            n = (kind == K_RTI && CCR_EN) ? 3 : 2;
            for (int k = 1; k <= n; k++) exp_read(s + 32'(k));
            if (n == 3) begin
                w = ref_mem[ad(s + 32'd1)];
                f.ccr_wr = 1'b1;
                f.ccr = w[4:0];
            end
            f.pc = {ref_mem[ad(s + 32'(n))], ref_mem[ad(s + 32'(n - 1))]};
            f.sp = s + 32'(n);
            exp_lat.push_back(n + 2);
        end
        exp_fin.push_back(f);
        m_sp = f.sp;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(posedge clk); #1;
            int_req = 1'b0;
            n++;
        end while (!busy && n < 20);
        if (!busy) drv_timeouts++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) drv_timeouts++;
    endtask

    task automatic scramble();
        pc_in = $urandom; sp_in = $urandom;
        call_target = 16'($urandom); ccr_in = 5'($urandom);
    endtask

    task automatic run_op(input int kind, input logic [31:0] pc,
                          input logic [15:0] tgt, input logic [4:0] ccr);
        sp_in = m_sp; pc_in = pc; call_target = tgt; ccr_in = ccr;
        model_op(kind, pc, tgt, ccr);
        case (kind)
            K_CALL:  call_req = 1'b1;
            K_RET:   ret_req  = 1'b1;
            K_INT:   int_req  = 1'b1;
            default: rti_req  = 1'b1;
        endcase
        wait_accept();
        call_req = 1'b0; ret_req = 1'b0; rti_req = 1'b0;
        scramble();
        wait_idle();
    endtask

    // Monitor: pops expectations whenever the DUT presents memory or strobe activity.
    logic prev_busy = 1'b0;
    int   busy_cnt = 0;
    int   cyc = 0;
    always @(negedge clk) begin
        mem_op_t op;
        fin_t f;
        int   l;
        cyc++;
        if (mon_en) begin
            if (mem_en) begin
                checks++;
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("FAIL mem_op: unexpected access rw=%0b addr=%h", mem_rw, mem_addr);
                end else begin
                    op = exp_mem.pop_front();
                    if (mem_rw !== op.rw || mem_addr !== op.addr || (op.rw && mem_wdata !== op.wdata)) begin
                        errors++;
                        $display("FAIL mem_op: got rw=%0b addr=%h wdata=%h, expected rw=%0b addr=%h wdata=%h",
                                 mem_rw, mem_addr, mem_wdata, op.rw, op.addr, op.wdata);
                    end
                end
            end
            if (pc_wr || sp_wr || ccr_wr) begin
                checks++;
                if (exp_fin.size() == 0) begin
                    errors++;
                    $display("FAIL finish: unexpected strobe pc=%h sp=%h", pc_out, sp_out);
                end else begin
                    f = exp_fin.pop_front();
                    if (!pc_wr || pc_out !== f.pc) begin
                        errors++;
                        $display("FAIL finish_pc: got wr=%0b pc=%h, expected pc=%h", pc_wr, pc_out, f.pc);
                    end
                    checks++;
                    if (!sp_wr || sp_out !== f.sp) begin
                        errors++;
                        $display("FAIL finish_sp: got wr=%0b sp=%h, expected sp=%h", sp_wr, sp_out, f.sp);
                    end
                    checks++;
                    if (ccr_wr !== f.ccr_wr || (f.ccr_wr && ccr_out !== f.ccr)) begin
                        errors++;
                        $display("FAIL finish_ccr: got wr=%0b ccr=%b, expected wr=%0b ccr=%b",
                                 ccr_wr, ccr_out, f.ccr_wr, f.ccr);
                    end
                end
            end
            if (!busy) begin
                checks++;
                if ({mem_en, mem_rw, mem_addr, mem_wdata, pc_wr, pc_out, sp_wr, sp_out, ccr_wr, ccr_out} != '0) begin
                    errors++;
                    $display("FAIL idle_outputs: got en=%0b rw=%0b addr=%h wd=%h pcw=%0b pc=%h spw=%0b sp=%h, expected all 0",
                             mem_en, mem_rw, mem_addr, mem_wdata, pc_wr, pc_out, sp_wr, sp_out);
                end
                if (call_req || ret_req || rti_req || int_req) begin
                    checks++;
                    if (stall !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_request: got %0b, expected 1", stall);
                    end
                end
            end else begin
                busy_cnt++;
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_busy: got %0b, expected 1", stall);
                end
            end
            if (prev_busy && !busy) begin
                checks++;
                l = (exp_lat.size() == 0) ? -1 : exp_lat.pop_front();
                if (busy_cnt != l) begin
                    errors++;
                    $display("FAIL latency: got %0d busy cycles, expected %0d", busy_cnt, l);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
        if (test_done || cyc > 50000) begin
            checks++;
            if (cyc > 50000 || drv_timeouts != 0) begin
                errors++;
                $display("FAIL timeout: got %0d expired waits at cycle %0d, expected 0", drv_timeouts, cyc);
            end
            checks++;
            if (exp_mem.size() != 0 || exp_fin.size() != 0 || exp_lat.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d mem / %0d finish / %0d latency pending, expected 0",
                         exp_mem.size(), exp_fin.size(), exp_lat.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        logic [31:0] sp_mid;
        reset = 1'b1; mem_init = 1'b1;
        call_req = 1'b0; ret_req = 1'b0; rti_req = 1'b0; int_req = 1'b0;
        pc_in = '0; sp_in = '0; call_target = '0; ccr_in = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = fill(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; mem_init = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;

        // CALL then RET through the top of memory
        m_sp = 32'h0000_0FFF;
        run_op(K_CALL, 32'h0001_0234, 16'h0050, 5'd0);
        run_op(K_RET,  32'h0000_1111, 16'h0000, 5'd0);

        // Simultaneous CALL and INT: INT wins, held CALL follows
        m_sp = 32'h0000_0800;
        pc_in = 32'h0002_0A0A; call_target = 16'h0123; ccr_in = 5'b01101; sp_in = m_sp;
        model_op(K_INT, pc_in, call_target, ccr_in);
        sp_mid = m_sp;
        model_op(K_CALL, pc_in, call_target, ccr_in);
        call_req = 1'b1; int_req = 1'b1;
        wait_accept();
        sp_in = sp_mid;
        wait_idle();
        wait_accept();
        call_req = 1'b0;
        scramble();
        wait_idle();

        // INT pulse during RET POP_HI is deferred until RET finishes
        pc_in = 32'h0003_BEEF; call_target = 16'h0000; ccr_in = 5'b00110; sp_in = m_sp;
        model_op(K_RET, pc_in, call_target, ccr_in);
        sp_mid = m_sp;
        model_op(K_INT, pc_in, call_target, ccr_in);
        ret_req = 1'b1;
        wait_accept();
        ret_req = 1'b0;
        sp_in = sp_mid;
        @(posedge clk); #1;
        int_req = 1'b1;
        @(posedge clk); #1;
        int_req = 1'b0;
        wait_idle();
        wait_accept();
        wait_idle();

        // Reset in PUSH_LO: two words written, no strobes
        sp_in = m_sp; pc_in = 32'hCAFE_F00D; call_target = 16'h0777;
        exp_write(m_sp, 16'hCAFE);
        exp_write(m_sp - 32'd1, 16'hF00D);
        exp_lat.push_back(2);
        call_req = 1'b1;
        wait_accept();
        call_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Wrap below address zero
        m_sp = 32'h0000_0000;
        run_op(K_CALL, 32'h0004_5678, 16'h0ABC, 5'd0);
        run_op(K_RET,  32'h0, 16'h0, 5'd0);

        // INT with CCR then RTI
        m_sp = 32'h0000_0FFF;
        run_op(K_INT, 32'h0005_0042, 16'h0000, 5'b10101);
        run_op(K_RTI, 32'h0, 16'h0, 5'b00000);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0: m_sp = $urandom;
                1: m_sp = 32'h0000_0000;
                2: m_sp = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(int'($urandom_range(0, 3)), $urandom, 16'($urandom), 5'($urandom));
        end

        repeat (3) @(posedge clk);
        test_done = 1'b1;
    end
endmodule
`default_nettype wire
